// File: rtl/rect_grid_sampler_pkg.sv
// rect_grid_sampler_pkg: shared frame/rectangle constants, item field layout and slot helpers
package rect_grid_sampler_pkg;
    localparam int RECT_NUMMAX    = 4;
    localparam int OV5640_X       = 640;
    localparam int OV5640_Y       = 480;
    localparam int POSITION_WIDTH = 12;
    localparam int GRID_SIZE      = 8;
    localparam int XMIN_LSB       = 24;
    localparam int YMIN_LSB       = 16;
    localparam int XMAX_LSB       = 8;
    localparam int YMAX_LSB       = 0;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    typedef struct packed {
        logic [7:0] x_min;
        logic [7:0] y_min;
        logic [7:0] x_max;
        logic [7:0] y_max;
    } rect_t;

    function automatic rect_t get_rect(input logic [31:0] w);
        return '{x_min: w[XMIN_LSB+:8], y_min: w[YMIN_LSB+:8], x_max: w[XMAX_LSB+:8], y_max: w[YMAX_LSB+:8]};
    endfunction

    // A slot must span at least grid_n pixels on both axes (bounds are 4-pixel units, inclusive).
    function automatic logic slot_ok(input rect_t r, input int grid_n);
        return (4 * (int'(r.x_max) - int'(r.x_min)) + 1 >= grid_n) &&
               (4 * (int'(r.y_max) - int'(r.y_min)) + 1 >= grid_n);
    endfunction
endpackage

// File: rtl/rect_grid_sampler_grid_buf.sv
// rect_grid_sampler_grid_buf: simple dual-port sample RAM with 1-cycle registered read
module rect_grid_sampler_grid_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rd_data
);
    logic [15:0] mem [DEPTH];
    logic [15:0] rd_data_q;

    always_ff @(posedge sys_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_data_q <= mem[raddr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/rect_grid_sampler.sv
// rect_grid_sampler: round-robin picks one rectangle per frame, nearest-neighbour samples it
// onto a GRID_N x GRID_N grid and streams the grid out over valid/ready.
module rect_grid_sampler
    import rect_grid_sampler_pkg::*;
#(
    parameter int RECT_NUM = RECT_NUMMAX,
    parameter int GRID_N   = GRID_SIZE,
    parameter int FRM_X    = OV5640_X,
    parameter int FRM_Y    = OV5640_Y,
    parameter int P_W      = POSITION_WIDTH,
    localparam int RW      = RECT_NUM > 1 ? $clog2(RECT_NUM) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [RECT_NUM*32-1:0] i_item,
    input  logic                i_valid,
    input  logic [15:0]         i_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [15:0]         o_data,
    output logic                o_last,
    output logic [RW-1:0]       o_rect_idx,
    output logic                o_busy
);
    localparam int GL = $clog2(GRID_N);
    localparam int AB = 2 * GL;
    localparam int DW = P_W + 1;

    state_t          state_q, state_d;
    logic [P_W-1:0]  cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [RW-1:0]   rr_q, rr_d, sel_q, sel_d, pick, next_sel, o_idx_q, o_idx_d;
    rect_t           rect_q, rect_d, cur;
    logic [DW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [GL-1:0]   row_q, row_d, col_q, col_d, row_b, col_b;
    logic [AB-1:0]   rd_addr_q, rd_addr_d;
    logic            issued_q, issued_d, dvld_q, dvld_d, dlast_q, dlast_d;
    logic            o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [15:0]     o_data_q, o_data_d, rd_data;
    logic            found, sof, eof, active, in_rect, xs, ys, col_hit, row_hit;
    logic            hit, we, eol, done, re, load_out, in_drain;
    logic [DW-1:0]   cx, cy, x0, x1, y0, y1, w, h, tx, ty;
    int              s;

    // Round-robin priority search starting at rr_q, evaluated on the live item list.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        s     = 0;
        for (int i = 0; i < RECT_NUM; i++) begin
            s = int'(rr_q) + i;
            if (s >= RECT_NUM) s = s - RECT_NUM;
            if (!found && slot_ok(get_rect(i_item[s*32+:32]), GRID_N)) begin
                found = 1'b1;
                pick  = RW'(s);
            end
        end
    end

    assign sof      = i_valid && cnt_x_q == '0 && cnt_y_q == '0;
    assign eof      = i_valid && cnt_x_q == P_W'(FRM_X - 1) && cnt_y_q == P_W'(FRM_Y - 1);
    assign cur      = state_q == IDLE ? get_rect(i_item[int'(pick)*32+:32]) : rect_q;
    assign active   = i_valid && (state_q == CAPTURE || (state_q == IDLE && sof && found));
    assign cx       = DW'(cnt_x_q);
    assign cy       = DW'(cnt_y_q);
    assign x0       = DW'({cur.x_min, 2'b00});
    assign x1       = DW'({cur.x_max, 2'b00});
    assign y0       = DW'({cur.y_min, 2'b00});
    assign y1       = DW'({cur.y_max, 2'b00});
    assign w        = x1 - x0 + DW'(1);
    assign h        = y1 - y0 + DW'(1);
    assign tx       = acc_x_q + DW'(GRID_N);
    assign ty       = acc_y_q + DW'(GRID_N);
    assign in_rect  = cx >= x0 && cx <= x1 && cy >= y0 && cy <= y1;
    assign xs       = cx == x0;
    assign ys       = cy == y0;
    assign col_hit  = xs || tx >= w;
    assign row_hit  = ys || ty >= h;
    // Grid indices restart from zero whenever a capture begins out of IDLE.
    assign row_b    = state_q == IDLE ? '0 : row_q;
    assign col_b    = state_q == IDLE ? '0 : col_q;
    assign hit      = active && in_rect;
    assign we       = hit && row_hit && col_hit;
    assign eol      = hit && row_hit && cx == x1;
    assign done     = we && row_b == GL'(GRID_N - 1) && col_b == GL'(GRID_N - 1);
    assign next_sel = sel_q == RW'(RECT_NUM - 1) ? '0 : sel_q + RW'(1);
    assign in_drain = state_q == DRAIN;
    assign load_out = dvld_q && (!o_valid_q || o_ready);
    assign re       = in_drain && !issued_q && (!dvld_q || load_out);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        rect_d  = rect_q;
        unique case (state_q)
            IDLE: if (sof && found) begin
                state_d = CAPTURE;
                sel_d   = pick;
                rect_d  = cur;
            end
            CAPTURE: if (done || eof) begin
                state_d = done ? DRAIN : IDLE;
                rr_d    = next_sel;
            end
            DRAIN: if (o_valid_q && o_ready && o_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_x_d   = !i_valid ? cnt_x_q : cnt_x_q == P_W'(FRM_X - 1) ? '0 : cnt_x_q + P_W'(1);
        cnt_y_d   = !(i_valid && cnt_x_q == P_W'(FRM_X - 1)) ? cnt_y_q :
                    cnt_y_q == P_W'(FRM_Y - 1) ? '0 : cnt_y_q + P_W'(1);
        acc_x_d   = hit ? (xs ? '0 : tx >= w ? tx - w : tx) : acc_x_q;
        acc_y_d   = hit && cx == x1 ? (ys ? '0 : ty >= h ? ty - h : ty) : acc_y_q;
        col_d     = eol ? '0 : we ? col_b + GL'(1) : col_b;
        row_d     = eol ? row_b + GL'(1) : row_b;
        rd_addr_d = !in_drain ? '0 : re ? rd_addr_q + AB'(1) : rd_addr_q;
        issued_d  = in_drain && (issued_q || (re && &rd_addr_q));
        dvld_d    = in_drain && (re || (dvld_q && !load_out));
        dlast_d   = re ? &rd_addr_q : dlast_q;
        o_valid_d = load_out || (o_valid_q && !o_ready);
        o_data_d  = load_out ? rd_data : o_data_q;
        o_last_d  = load_out ? dlast_q : o_last_q;
        o_idx_d   = load_out ? sel_q : o_idx_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
            rr_q      <= '0;
            sel_q     <= '0;
            rect_q    <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rd_addr_q <= '0;
            issued_q  <= 1'b0;
            dvld_q    <= 1'b0;
            dlast_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            rect_q    <= rect_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_addr_q <= rd_addr_d;
            issued_q  <= issued_d;
            dvld_q    <= dvld_d;
            dlast_q   <= dlast_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_idx_q   <= o_idx_d;
        end
    end

    rect_grid_sampler_grid_buf #(.DEPTH(GRID_N * GRID_N), .AW(AB)) u_grid_buf (
        .sys_clk (sys_clk),
        .we      (we),
        .waddr   ({row_b, col_b}),
        .wdata   (i_data),
        .re      (re),
        .raddr   (rd_addr_q),
        .rd_data (rd_data)
    );

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_last     = o_last_q;
    assign o_rect_idx = o_idx_q;
    assign o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_rect_grid_sampler.sv
// tb_rect_grid_sampler: table-driven frame scenarios plus a stall/reset sequence
module tb_rect_grid_sampler;
    localparam int FX = 64;
    localparam int FY = 48;
    localparam int RN = 4;
    localparam int GN = 8;
    localparam int NPIX = FX * FY;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [RN*32-1:0] i_item = '0;
    logic          i_valid = 1'b0;
    logic [15:0]   i_data = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [15:0]   o_data;
    logic          o_last;
    logic [1:0]    o_rect_idx;
    logic          o_busy;

    int errs = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    rect_grid_sampler #(.RECT_NUM(RN), .GRID_N(GN), .FRM_X(FX), .FRM_Y(FY), .P_W(12)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_item     (i_item),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_rect_idx (o_rect_idx),
        .o_busy     (o_busy)
    );

    typedef struct {
        bit           rst;
        logic [127:0] item;
        logic [3:0]   pat;
        bit           exp_out;
        int           exp_idx;
        bit           chk_idle;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [31:0] mk(input int xn, input int yn, input int xm, input int ym);
        return {8'(xn), 8'(yn), 8'(xm), 8'(ym)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // One full frame of raster pixels {y,x} followed by an idle tail; collects and checks the grid.
    task automatic run_frame(input vec_t v, input int id);
        logic [15:0] gd[64];
        logic        gl[64];
        logic [1:0]  gi[64];
        logic [31:0] r;
        logic [15:0] pdata;
        int n, x0, y0, ww, hh, px, py;
        bit pstall, busy_seen;
        n = 0;
        pstall = 0;
        busy_seen = 0;
        pdata = '0;
        i_item = v.item;
        for (int c = 0; c < NPIX + 300; c++) begin
            @(posedge sys_clk);
            #1;
            i_valid = c < NPIX;
            i_data = {8'(c / FX), 8'(c % FX)};
            o_ready = v.pat[c % 4];
            @(negedge sys_clk);
            if (o_busy) busy_seen = 1;
            if (pstall) begin
                chk($sformatf("hold_valid[%0d]", id), o_valid, 1);
                chk($sformatf("hold_data[%0d]", id), o_data, pdata);
            end
            if (o_valid && o_ready) begin
                if (n < 64) begin
                    gd[n] = o_data;
                    gl[n] = o_last;
                    gi[n] = o_rect_idx;
                end
                n++;
            end
            pstall = o_valid && !o_ready;
            pdata = o_data;
        end
        i_valid = 1'b0;
        if (v.chk_idle) chk($sformatf("idle_busy[%0d]", id), busy_seen, 0);
        if (!v.exp_out) chk($sformatf("no_output[%0d]", id), n, 0);
        else begin
            chk($sformatf("word_count[%0d]", id), n, 64);
            r = v.item[v.exp_idx*32+:32];
            x0 = 4 * int'(r[31:24]);
            y0 = 4 * int'(r[23:16]);
            ww = 4 * int'(r[15:8]) - x0 + 1;
            hh = 4 * int'(r[7:0]) - y0 + 1;
            for (int k = 0; k < 64 && k < n; k++) begin
                px = x0 + ((k % GN) * ww + GN - 1) / GN;
                py = y0 + ((k / GN) * hh + GN - 1) / GN;
                chk($sformatf("data[%0d][%0d]", id, k), gd[k], {8'(py), 8'(px)});
                chk($sformatf("last[%0d][%0d]", id, k), gl[k], k == 63);
                chk($sformatf("idx[%0d][%0d]", id, k), gi[k], v.exp_idx);
            end
        end
    endtask

    initial begin
        logic [127:0] ia, ib, ic, id4, ie;
        ia  = {32'h0, 32'h0, 32'h0, mk(2, 2, 9, 9)};
        ib  = {32'h0, mk(4, 3, 11, 8), 32'h0, mk(2, 2, 9, 9)};
        ic  = {32'h0, 32'h0, mk(0, 0, 3, 3), mk(2, 2, 9, 15)};
        id4 = {mk(2, 2, 3, 9), mk(2, 2, 3, 9), mk(2, 2, 3, 9), mk(2, 2, 3, 9)};
        ie  = {32'h0, 32'h0, mk(2, 2, 9, 9), mk(1, 1, 8, 8)};
        tbl[0] = '{1, ia, 4'hF, 1, 0, 0};
        tbl[1] = '{1, ib, 4'hF, 1, 0, 0};
        tbl[2] = '{0, ib, 4'hF, 1, 2, 0};
        tbl[3] = '{0, ib, 4'hF, 1, 0, 0};
        tbl[4] = '{0, ib, 4'b1001, 1, 2, 0};
        tbl[5] = '{1, ic, 4'hF, 0, 0, 0};
        tbl[6] = '{0, ic, 4'hF, 1, 1, 0};
        tbl[7] = '{1, id4, 4'hF, 0, 0, 1};
        tbl[8] = '{0, ie, 4'hF, 1, 0, 0};

        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_idx", o_rect_idx, 0);
        chk("rst_busy", o_busy, 0);

        for (int t = 0; t < 9; t++) begin
            if (tbl[t].rst) do_reset();
            run_frame(tbl[t], t);
        end

        // Stall the first word across the next SOF, then reset asynchronously while draining.
        do_reset();
        i_item = ia;
        for (int c = 0; c < NPIX + 200; c++) begin
            @(posedge sys_clk);
            #1;
            i_valid = 1'b1;
            i_data = {8'((c % NPIX) / FX), 8'(c % FX)};
            o_ready = 1'b0;
        end
        @(negedge sys_clk);
        chk("stall_valid", o_valid, 1);
        chk("stall_busy", o_busy, 1);
        chk("stall_data", o_data, 16'h0808);
        chk("stall_idx", o_rect_idx, 0);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_data", o_data, 0);
        chk("arst_last", o_last, 0);
        i_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_frame(tbl[0], 9);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
